// File: rtl/vga_pattern_engine.sv
// Programmable VGA timing generator with a two-stage pixel pipeline producing
// colour bars, checkerboard, gradient or solid colour; pattern switches per frame.
module vga_pattern_engine #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int COLOR_BITS  = 4,
  parameter int NUM_BARS    = 4,
  parameter int CHECK_SHIFT = 5,
  parameter bit SYNC_POL    = 1'b0,
  localparam int X_W = $clog2(H_ACTIVE),
  localparam int Y_W = $clog2(V_ACTIVE)
) (
  input  logic                    clk_25,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [1:0]              mode,
  input  logic [3*COLOR_BITS-1:0] solid_rgb,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    de,
  output logic [COLOR_BITS-1:0]   red,
  output logic [COLOR_BITS-1:0]   green,
  output logic [COLOR_BITS-1:0]   blue,
  output logic [X_W-1:0]          pixel_x,
  output logic [Y_W-1:0]          pixel_y,
  output logic                    frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HC_W    = $clog2(H_TOTAL);
  localparam int VC_W    = $clog2(V_TOTAL);
  localparam int BAR_W   = H_ACTIVE / NUM_BARS;
  localparam int BP_W    = $clog2(BAR_W + 1);
  localparam int CB      = COLOR_BITS;

  logic [HC_W-1:0]   r_hCnt;
  logic [VC_W-1:0]   r_vCnt;
  logic [1:0]        r_modeQ;
  logic [3*CB-1:0]   r_solidQ;
  logic [2:0]        r_barIdx;
  logic [BP_W-1:0]   r_barPix;

  logic              w_hLast;
  logic              w_vLast;
  logic              w_de;
  logic              w_hsAct;
  logic              w_vsAct;
  logic              w_first;

  logic              r_s1De;
  logic              r_s1Hs;
  logic              r_s1Vs;
  logic              r_s1Fs;
  logic              r_s1En;
  logic [X_W-1:0]    r_s1X;
  logic [Y_W-1:0]    r_s1Y;
  logic [2:0]        r_s1Bar;
  logic [1:0]        r_s1Mode;
  logic [3*CB-1:0]   r_s1Solid;

  logic [2:0]        w_barCode;
  logic              w_chkX;
  logic              w_chkY;
  logic [CB-1:0]     w_gradR;
  logic [CB-1:0]     w_gradG;
  logic [CB-1:0]     w_red;
  logic [CB-1:0]     w_green;
  logic [CB-1:0]     w_blue;

  assign w_hLast = (r_hCnt == HC_W'(H_TOTAL - 1));
  assign w_vLast = (r_vCnt == VC_W'(V_TOTAL - 1));

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      r_hCnt <= '0;
      r_vCnt <= '0;
    end else if (w_hLast) begin
      r_hCnt <= '0;
      r_vCnt <= w_vLast ? '0 : r_vCnt + 1'b1;
    end else begin
      r_hCnt <= r_hCnt + 1'b1;
    end
  end

  // Pattern selection only moves on the last pixel of a frame so a frame is never mixed.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      r_modeQ  <= '0;
      r_solidQ <= '0;
    end else if (w_hLast && w_vLast) begin
      r_modeQ  <= mode;
      r_solidQ <= solid_rgb;
    end
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      r_barIdx <= '0;
      r_barPix <= '0;
    end else if (w_hLast) begin
      r_barIdx <= '0;
      r_barPix <= '0;
    end else if (r_hCnt < HC_W'(H_ACTIVE)) begin
      if (r_barPix == BP_W'(BAR_W - 1)) begin
        r_barPix <= '0;
        if (r_barIdx != 3'(NUM_BARS - 1)) r_barIdx <= r_barIdx + 1'b1;
      end else begin
        r_barPix <= r_barPix + 1'b1;
      end
    end
  end

  assign w_de    = (r_hCnt < HC_W'(H_ACTIVE)) && (r_vCnt < VC_W'(V_ACTIVE));
  assign w_hsAct = (r_hCnt >= HC_W'(H_ACTIVE + H_FP)) &&
                   (r_hCnt <  HC_W'(H_ACTIVE + H_FP + H_SYNC));
  assign w_vsAct = (r_vCnt >= VC_W'(V_ACTIVE + V_FP)) &&
                   (r_vCnt <  VC_W'(V_ACTIVE + V_FP + V_SYNC));
  assign w_first = (r_hCnt == '0) && (r_vCnt == '0);

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      r_s1De    <= 1'b0;
      r_s1Hs    <= 1'b0;
      r_s1Vs    <= 1'b0;
      r_s1Fs    <= 1'b0;
      r_s1En    <= 1'b0;
      r_s1X     <= '0;
      r_s1Y     <= '0;
      r_s1Bar   <= '0;
      r_s1Mode  <= '0;
      r_s1Solid <= '0;
    end else begin
      r_s1De    <= w_de;
      r_s1Hs    <= w_hsAct;
      r_s1Vs    <= w_vsAct;
      r_s1Fs    <= w_first;
      r_s1En    <= enable;
      r_s1X     <= X_W'(r_hCnt);
      r_s1Y     <= Y_W'(r_vCnt);
      r_s1Bar   <= r_barIdx;
      r_s1Mode  <= r_modeQ;
      r_s1Solid <= r_solidQ;
    end
  end

  assign w_barCode = ~r_s1Bar;

  // Small rasters may have fewer coordinate bits than the pattern needs; missing bits read as 0.
  if (CHECK_SHIFT < X_W) begin : gen_chkX
    assign w_chkX = r_s1X[CHECK_SHIFT];
  end else begin : gen_chkXZero
    assign w_chkX = 1'b0;
  end

  if (CHECK_SHIFT < Y_W) begin : gen_chkY
    assign w_chkY = r_s1Y[CHECK_SHIFT];
  end else begin : gen_chkYZero
    assign w_chkY = 1'b0;
  end

  if (X_W >= CB) begin : gen_gradX
    assign w_gradR = r_s1X[X_W-1 -: CB];
  end else begin : gen_gradXPad
    assign w_gradR = {r_s1X, {(CB - X_W){1'b0}}};
  end

  if (Y_W >= CB) begin : gen_gradY
    assign w_gradG = r_s1Y[Y_W-1 -: CB];
  end else begin : gen_gradYPad
    assign w_gradG = {r_s1Y, {(CB - Y_W){1'b0}}};
  end

  always_comb begin
    w_red   = '0;
    w_green = '0;
    w_blue  = '0;
    if (r_s1De && r_s1En) begin
      case (r_s1Mode)
        2'd0: begin
          w_red   = {CB{w_barCode[2]}};
          w_green = {CB{w_barCode[1]}};
          w_blue  = {CB{w_barCode[0]}};
        end
        2'd1: begin
          w_red   = {CB{w_chkX ^ w_chkY}};
          w_green = {CB{w_chkX ^ w_chkY}};
          w_blue  = {CB{w_chkX ^ w_chkY}};
        end
        2'd2: begin
          w_red   = w_gradR;
          w_green = w_gradG;
        end
        default: begin
          w_red   = r_s1Solid[3*CB-1 -: CB];
          w_green = r_s1Solid[2*CB-1 -: CB];
          w_blue  = r_s1Solid[CB-1:0];
        end
      endcase
    end
  end

  // Coordinates freeze during blanking so they always name the last visible pixel.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= r_s1Hs ? SYNC_POL : ~SYNC_POL;
      vsync       <= r_s1Vs ? SYNC_POL : ~SYNC_POL;
      de          <= r_s1De;
      red         <= w_red;
      green       <= w_green;
      blue        <= w_blue;
      frame_start <= r_s1Fs;
      if (r_s1De) begin
        pixel_x <= r_s1X;
        pixel_y <= r_s1Y;
      end
    end
  end

endmodule

// File: tb/tb_vga_pattern_engine.sv
// Bench for vga_pattern_engine: three raster sizes driven by shared random inputs and
// compared every cycle against a position-based reference model, plus directed checks.
module tb_vga_pattern_engine;

   localparam int HMAX = 40000;

   typedef struct {
      int ha, hf, hs, hb, va, vf, vs, vb, nb, cs, pol, xw, yw;
   } cfg_t;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic [1:0]  mode;
   logic [11:0] solid;

   logic        dD_hs, dD_vs, dD_de, dD_fs;
   logic [3:0]  dD_r, dD_g, dD_b;
   logic [9:0]  dD_x;
   logic [8:0]  dD_y;

   logic        dS_hs, dS_vs, dS_de, dS_fs;
   logic [3:0]  dS_r, dS_g, dS_b;
   logic [2:0]  dS_x;
   logic [1:0]  dS_y;

   logic        dM_hs, dM_vs, dM_de, dM_fs;
   logic [3:0]  dM_r, dM_g, dM_b;
   logic [5:0]  dM_x;
   logic [5:0]  dM_y;

   logic [1:0]  modeHist [0:HMAX-1];
   logic [11:0] solidHist [0:HMAX-1];
   logic        enHist [0:HMAX-1];

   cfg_t cD, cS, cM;
   int   k;
   int   total;
   int   bad;

   vga_pattern_engine dutD (
      .clk_25(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .solid_rgb(solid),
      .hsync(dD_hs), .vsync(dD_vs), .de(dD_de), .red(dD_r), .green(dD_g), .blue(dD_b),
      .pixel_x(dD_x), .pixel_y(dD_y), .frame_start(dD_fs)
   );

   vga_pattern_engine #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
   ) dutS (
      .clk_25(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .solid_rgb(solid),
      .hsync(dS_hs), .vsync(dS_vs), .de(dS_de), .red(dS_r), .green(dS_g), .blue(dS_b),
      .pixel_x(dS_x), .pixel_y(dS_y), .frame_start(dS_fs)
   );

   vga_pattern_engine #(
      .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
      .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(4),
      .NUM_BARS(3), .CHECK_SHIFT(3), .SYNC_POL(1'b1)
   ) dutM (
      .clk_25(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .solid_rgb(solid),
      .hsync(dM_hs), .vsync(dM_vs), .de(dM_de), .red(dM_r), .green(dM_g), .blue(dM_b),
      .pixel_x(dM_x), .pixel_y(dM_y), .frame_start(dM_fs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Guards against a stalled run; every wait below is clock-counted anyway.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired k=%0d", k);
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [63:0] pack(bit hs, bit vs, bit de, bit fs,
                                        int r, int g, int b, int x, int y);
      return {16'd0, hs, vs, de, fs, r[3:0], g[3:0], b[3:0], x[15:0], y[15:0]};
   endfunction

   // Expected outputs after kk clock edges since reset release, from raster arithmetic.
   function automatic logic [63:0] model(cfg_t c, int kk);
      int ht, vt, ft, p, h, v, f, x, y, r, g, b, md, bar, code;
      bit de, hsA, vsA, fs, en, pl;
      logic [11:0] sd;
      pl = (c.pol != 0);
      if (kk < 2) return pack(!pl, !pl, 1'b0, 1'b0, 0, 0, 0, 0, 0);
      ht  = c.ha + c.hf + c.hs + c.hb;
      vt  = c.va + c.vf + c.vs + c.vb;
      ft  = ht * vt;
      p   = kk - 2;
      h   = p % ht;
      v   = (p / ht) % vt;
      f   = p / ft;
      de  = (h < c.ha) && (v < c.va);
      hsA = (h >= c.ha + c.hf) && (h < c.ha + c.hf + c.hs);
      vsA = (v >= c.va + c.vf) && (v < c.va + c.vf + c.vs);
      fs  = (p % ft) == 0;
      if (de) begin
         x = h; y = v;
      end else if (v < c.va) begin
         x = c.ha - 1; y = v;
      end else begin
         x = c.ha - 1; y = c.va - 1;
      end
      md = (f == 0) ? 0 : int'(modeHist[f * ft]);
      sd = (f == 0) ? 12'h000 : solidHist[f * ft];
      en = enHist[kk - 1];
      r = 0; g = 0; b = 0;
      if (de && en) begin
         case (md)
            0: begin
               bar = h / (c.ha / c.nb);
               if (bar > c.nb - 1) bar = c.nb - 1;
               code = ~bar & 7;
               r = (code & 4) != 0 ? 15 : 0;
               g = (code & 2) != 0 ? 15 : 0;
               b = (code & 1) != 0 ? 15 : 0;
            end
            1: begin
               if ((((h >> c.cs) ^ (v >> c.cs)) & 1) != 0) begin
                  r = 15; g = 15; b = 15;
               end
            end
            2: begin
               r = ((h << 4) >> c.xw) & 15;
               g = ((v << 4) >> c.yw) & 15;
            end
            default: begin
               r = int'(sd[11:8]); g = int'(sd[7:4]); b = int'(sd[3:0]);
            end
         endcase
      end
      return pack(hsA ? pl : !pl, vsA ? pl : !pl, de, fs, r, g, b, x, y);
   endfunction

   task automatic checkOutput(string tag, logic [63:0] obs, logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
      end
   endtask

   task automatic checkAll();
      checkOutput("dutD", pack(dD_hs, dD_vs, dD_de, dD_fs, int'(dD_r), int'(dD_g), int'(dD_b),
                               int'(dD_x), int'(dD_y)), model(cD, k));
      checkOutput("dutS", pack(dS_hs, dS_vs, dS_de, dS_fs, int'(dS_r), int'(dS_g), int'(dS_b),
                               int'(dS_x), int'(dS_y)), model(cS, k));
      checkOutput("dutM", pack(dM_hs, dM_vs, dM_de, dM_fs, int'(dM_r), int'(dM_g), int'(dM_b),
                               int'(dM_x), int'(dM_y)), model(cM, k));
   endtask

   // Records the inputs seen by the coming edge, clocks once, then checks at the falling edge.
   task automatic applyStimulus();
      if (k + 1 >= HMAX) begin
         $display("[TB] FAIL history bound k=%0d", k);
         $fatal(1, "[TB] history bound");
      end
      modeHist[k + 1]  = mode;
      solidHist[k + 1] = solid;
      enHist[k + 1]    = enable;
      @(posedge clk);
      k++;
      @(negedge clk);
      checkAll();
   endtask

   initial begin
      int barX [6] = '{0, 159, 160, 320, 480, 639};
      logic [11:0] barRgb [6] = '{12'hFFF, 12'hFFF, 12'hFF0, 12'hF0F, 12'hF00, 12'hF00};
      int hsLow, deCnt, fsS;
      cD = '{640, 16, 96, 48, 480, 10, 2, 33, 4, 5, 0, 10, 9};
      cS = '{8, 2, 2, 2, 4, 1, 1, 1, 4, 5, 0, 3, 2};
      cM = '{64, 4, 8, 4, 48, 2, 2, 4, 3, 3, 1, 6, 6};
      total = 0; bad = 0; k = 0;
      hsLow = 0; deCnt = 0; fsS = 0;
      rst_n = 1'b0; enable = 1'b1; mode = 2'd0; solid = 12'h000;

      repeat (3) @(negedge clk);
      checkAll();
      rst_n = 1'b1;
      k = 0;

      // First line of the default raster, with a mid-frame mode change on the small one.
      for (int i = 0; i < 800; i++) begin
         if (k == 140) begin
            mode  = 2'd3;
            solid = 12'h5A3;
         end
         applyStimulus();
         if (k == 1) checkOutput("fsBeforeFirst", 64'(dD_fs), 64'd0);
         if (k == 2) checkOutput("fsFirst", 64'(dD_fs), 64'd1);
         if (k >= 2) begin
            if (!dD_hs) hsLow++;
            if (dD_de) deCnt++;
         end
         if (k >= 2 && k < 296 && dS_fs) fsS++;
         for (int j = 0; j < 6; j++)
            if (k - 2 == barX[j])
               checkOutput($sformatf("bar_x%0d", barX[j]), 64'({dD_r, dD_g, dD_b}), 64'(barRgb[j]));
         if (k == 198) begin
            checkOutput("modeSwitchRgb", 64'({dS_r, dS_g, dS_b}), 64'h5A3);
            checkOutput("modeSwitchFs", 64'(dS_fs), 64'd1);
         end
      end
      checkOutput("hsyncLowPerLine", 64'(hsLow), 64'd96);
      checkOutput("dePerLine", 64'(deCnt), 64'd640);
      checkOutput("smallFramesIn294", 64'(fsS), 64'd3);

      // Enable dropped in the middle of the second visible line.
      while (k < 902) applyStimulus();
      enable = 1'b0;
      applyStimulus();
      applyStimulus();
      checkOutput("enableOffRgb", 64'({dD_r, dD_g, dD_b}), 64'h000);
      checkOutput("enableOffDe", 64'(dD_de), 64'd1);
      repeat (50) applyStimulus();
      enable = 1'b1;
      repeat (20) applyStimulus();

      // Asynchronous reset mid-line, then restart from (0,0).
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("asyncResetD", pack(dD_hs, dD_vs, dD_de, dD_fs, int'(dD_r), int'(dD_g),
                  int'(dD_b), int'(dD_x), int'(dD_y)), pack(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0));
      @(negedge clk);
      k = 0;
      checkAll();
      @(negedge clk);
      rst_n = 1'b1;
      mode  = 2'd0;
      applyStimulus();
      applyStimulus();
      checkOutput("fsAfterReset", 64'(dD_fs), 64'd1);

      // Random mode, colour and enable traffic across many small and medium frames.
      for (int i = 0; i < 30000; i++) begin
         if ($urandom_range(0, 49) == 0) begin
            mode  = 2'($urandom);
            solid = 12'($urandom);
         end
         if ($urandom_range(0, 29) == 0) enable = ~enable;
         applyStimulus();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
